// File: rtl/systolic_2x2_seq.sv
// Sequencer for a 2x2 systolic multiplier: latches one A/B job, clears and feeds the array in
// diagonal-skewed order, then captures results on done (or timeout) and holds them for the consumer.
module systolic_2x2_seq #(
  parameter int DATA_W    = 32,
  parameter int DRAIN_MAX = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                in_ready,
  input  logic [4*DATA_W-1:0] a_mat,
  input  logic [4*DATA_W-1:0] b_mat,
  output logic                arr_clr,
  output logic                arr_load,
  output logic [DATA_W-1:0]   arr_row0,
  output logic [DATA_W-1:0]   arr_row1,
  output logic [DATA_W-1:0]   arr_col0,
  output logic [DATA_W-1:0]   arr_col1,
  input  logic [8*DATA_W-1:0] arr_res,
  input  logic [3:0]          arr_carry,
  input  logic                arr_done,
  output logic [8*DATA_W-1:0] c_mat,
  output logic [3:0]          c_carry,
  output logic                timeout_err,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_FEED0 = 3'd2;
  localparam logic [2:0] S_FEED1 = 3'd3;
  localparam logic [2:0] S_FEED2 = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;
  localparam logic [2:0] S_HOLD  = 3'd6;

  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_MAX - 1);

  logic [2:0]          state_q, state_d;
  logic [4*DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [8*DATA_W-1:0] c_mat_q, c_mat_d;
  logic [3:0]          c_carry_q, c_carry_d;
  logic                tmo_q, tmo_d;
  logic                clr_q, clr_d, load_q, load_d;
  logic [DATA_W-1:0]   row0_q, row0_d, row1_q, row1_d;
  logic [DATA_W-1:0]   col0_q, col0_d, col1_q, col1_d;

  logic [DATA_W-1:0] a00, a01, a10, a11, b00, b01, b10, b11;

  assign a00 = a_q[0*DATA_W +: DATA_W];
  assign a01 = a_q[1*DATA_W +: DATA_W];
  assign a10 = a_q[2*DATA_W +: DATA_W];
  assign a11 = a_q[3*DATA_W +: DATA_W];
  assign b00 = b_q[0*DATA_W +: DATA_W];
  assign b01 = b_q[1*DATA_W +: DATA_W];
  assign b10 = b_q[2*DATA_W +: DATA_W];
  assign b11 = b_q[3*DATA_W +: DATA_W];

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    c_mat_d   = c_mat_q;
    c_carry_d = c_carry_q;
    tmo_d     = tmo_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a_mat;
          b_d     = b_mat;
          state_d = S_CLR;
        end
      end
      S_CLR:   state_d = S_FEED0;
      S_FEED0: state_d = S_FEED1;
      S_FEED1: state_d = S_FEED2;
      S_FEED2: begin
        cnt_d   = 8'd0;
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // done takes priority over a coincident timeout
        if (arr_done || (cnt_q == DRAIN_LAST)) begin
          c_mat_d   = arr_res;
          c_carry_d = arr_carry;
          tmo_d     = !arr_done;
          state_d   = S_HOLD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_HOLD: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Array-side outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    clr_d  = 1'b0;
    load_d = 1'b0;
    row0_d = '0;
    row1_d = '0;
    col0_d = '0;
    col1_d = '0;
    case (state_d)
      S_CLR: clr_d = 1'b1;
      S_FEED0: begin
        load_d = 1'b1;
        row0_d = a00;
        col0_d = b00;
      end
      S_FEED1: begin
        load_d = 1'b1;
        row0_d = a01;
        row1_d = a10;
        col0_d = b10;
        col1_d = b01;
      end
      S_FEED2: begin
        load_d = 1'b1;
        row1_d = a11;
        col1_d = b11;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      c_mat_q   <= '0;
      c_carry_q <= '0;
      tmo_q     <= 1'b0;
      clr_q     <= 1'b0;
      load_q    <= 1'b0;
      row0_q    <= '0;
      row1_q    <= '0;
      col0_q    <= '0;
      col1_q    <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      c_mat_q   <= c_mat_d;
      c_carry_q <= c_carry_d;
      tmo_q     <= tmo_d;
      clr_q     <= clr_d;
      load_q    <= load_d;
      row0_q    <= row0_d;
      row1_q    <= row1_d;
      col0_q    <= col0_d;
      col1_q    <= col1_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign out_valid   = (state_q == S_HOLD);
  assign arr_clr     = clr_q;
  assign arr_load    = load_q;
  assign arr_row0    = row0_q;
  assign arr_row1    = row1_q;
  assign arr_col0    = col0_q;
  assign arr_col1    = col1_q;
  assign c_mat       = c_mat_q;
  assign c_carry     = c_carry_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_systolic_2x2_seq.sv
// Bench for systolic_2x2_seq: behavioural array model plus result scoreboard.
module tb_systolic_2x2_seq;

  localparam int DW   = 32;
  localparam int DMAX = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            in_ready;
  logic [4*DW-1:0] a_mat, b_mat;
  logic            arr_clr, arr_load;
  logic [DW-1:0]   arr_row0, arr_row1, arr_col0, arr_col1;
  logic [8*DW-1:0] arr_res;
  logic [3:0]      arr_carry;
  logic            arr_done;
  logic [8*DW-1:0] c_mat;
  logic [3:0]      c_carry;
  logic            timeout_err, out_valid, out_ready, busy;

  systolic_2x2_seq #(.DATA_W(DW), .DRAIN_MAX(DMAX)) dut (
    .clk(clk), .rst(rst), .start(start), .in_ready(in_ready),
    .a_mat(a_mat), .b_mat(b_mat), .arr_clr(arr_clr), .arr_load(arr_load),
    .arr_row0(arr_row0), .arr_row1(arr_row1), .arr_col0(arr_col0), .arr_col1(arr_col1),
    .arr_res(arr_res), .arr_carry(arr_carry), .arr_done(arr_done),
    .c_mat(c_mat), .c_carry(c_carry), .timeout_err(timeout_err),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8*DW-1:0] res;
    logic [3:0]      car;
    logic            tmo;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   done_cnt = 0;

  // current job, shared with the array model and monitor
  logic [DW-1:0]   cur_a[2][2];
  logic [DW-1:0]   cur_b[2][2];
  logic [8*DW-1:0] cur_prod;
  logic [3:0]      cur_pcar;
  int              done_at = 1000;
  int              hold_cur = 0;

  task automatic chk(input string nm, input logic [8*DW-1:0] act, input logic [8*DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [8*DW-1:0] pat(input int k);
    logic [8*DW-1:0] p;
    for (int e = 0; e < 4; e++) p[e*64 +: 64] = {32'hBAD00000 + 32'(k), 32'(e)};
    return p;
  endfunction

  function automatic logic [3:0] pat_car(input int k);
    return 4'(k) ^ 4'hA;
  endfunction

  // element fed to row r / column c on feed step f of a skewed wavefront
  function automatic logic [DW-1:0] row_exp(input int f, input int r);
    int k = f - r;
    return (k >= 0 && k <= 1) ? cur_a[r][k] : '0;
  endfunction

  function automatic logic [DW-1:0] col_exp(input int f, input int c);
    int k = f - c;
    return (k >= 0 && k <= 1) ? cur_b[k][c] : '0;
  endfunction

  function automatic logic [4*DW-1:0] pack4(input logic [DW-1:0] e00, e01, e10, e11);
    return {e11, e10, e01, e00};
  endfunction

  // Array model: checks the feed sequence and answers with results during the drain phase.
  initial begin
    int feed = 0, clr_n = 0, load_n = 0, dc = 0;
    bit hold_seen = 0;
    arr_done = 0; arr_res = '0; arr_carry = '0;
    forever begin
      @(negedge clk);
      if (!rst || !busy) begin
        feed = 0; clr_n = 0; load_n = 0; dc = 0; hold_seen = 0;
        arr_done  = 1'($urandom);
        arr_res   = {8{$urandom}};
        arr_carry = 4'($urandom);
      end else if (arr_clr) begin
        clr_n++;
        chk("clr_load", arr_load, 0);
        chk("clr_bus", {arr_row0, arr_row1, arr_col0, arr_col1}, 0);
        arr_done = 1'($urandom);
        arr_res  = {8{$urandom}};
      end else if (arr_load) begin
        load_n++;
        chk($sformatf("feed%0d_row0", feed), arr_row0, row_exp(feed, 0));
        chk($sformatf("feed%0d_row1", feed), arr_row1, row_exp(feed, 1));
        chk($sformatf("feed%0d_col0", feed), arr_col0, col_exp(feed, 0));
        chk($sformatf("feed%0d_col1", feed), arr_col1, col_exp(feed, 1));
        feed++;
        arr_done = 1'($urandom);
        arr_res  = {8{$urandom}};
      end else if (out_valid) begin
        if (!hold_seen) begin
          chk("clr_cycles", 32'(clr_n), 1);
          chk("load_cycles", 32'(load_n), 3);
          hold_seen = 1;
        end
        arr_done  = 1'($urandom);
        arr_res   = {8{$urandom}};
        arr_carry = 4'($urandom);
      end else begin
        chk("drain_bus", {arr_row0, arr_row1, arr_col0, arr_col1}, 0);
        arr_done  = (dc == done_at);
        arr_res   = arr_done ? cur_prod : pat(dc);
        arr_carry = arr_done ? cur_pcar : pat_car(dc);
        dc++;
      end
    end
  end

  // Monitor: compares held results each valid cycle, pops on handshake.
  initial begin
    int vcnt = 0;
    out_ready = 0;
    forever begin
      @(negedge clk);
      if (rst && out_valid) begin
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_result: got c_mat %h expected no result", c_mat);
          out_ready = 1;
        end else begin
          chk("c_mat", c_mat, sb[0].res);
          chk("c_carry", c_carry, sb[0].car);
          chk("timeout_err", timeout_err, sb[0].tmo);
          chk("in_ready_hold", in_ready, 0);
          vcnt++;
          out_ready = (vcnt > hold_cur);
          if (out_ready) begin
            void'(sb.pop_front());
            done_cnt++;
            vcnt = 0;
          end
        end
      end else begin
        out_ready = 0;
        vcnt = 0;
      end
    end
  end

  task automatic run_job(input logic [4*DW-1:0] a, input logic [4*DW-1:0] b,
                         input int dat, input int hold, input bit poke, input bit rst_mid);
    int n = 0;
    int target;
    bit poked = 0;
    exp_t e;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL in_ready_wait: got in_ready=0 expected 1 within 100 cycles");
      return;
    end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        logic [64:0] s;
        cur_a[i][j] = a[(2*i+j)*DW +: DW];
        cur_b[i][j] = b[(2*i+j)*DW +: DW];
      end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        logic [64:0] s;
        s = 65'(cur_a[i][0]) * 65'(cur_b[0][j]) + 65'(cur_a[i][1]) * 65'(cur_b[1][j]);
        cur_prod[(2*i+j)*64 +: 64] = s[63:0];
        cur_pcar[2*i+j] = s[64];
      end
    done_at  = dat;
    hold_cur = hold;
    if (dat < DMAX) begin
      e.res = cur_prod; e.car = cur_pcar; e.tmo = 1'b0;
    end else begin
      e.res = pat(DMAX - 1); e.car = pat_car(DMAX - 1); e.tmo = 1'b1;
    end
    if (!rst_mid) sb.push_back(e);
    target = done_cnt + 1;
    a_mat = a; b_mat = b; start = 1;
    @(posedge clk); #1;
    start = 0;
    a_mat = {4{$urandom}}; b_mat = {4{$urandom}};
    chk("accept_busy", busy, 1);
    chk("accept_in_ready", in_ready, 0);
    if (rst_mid) begin
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("mid_feed1_load", arr_load, 1);
      rst = 0;
      @(posedge clk); #1;
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_load", arr_load, 0);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_c_mat", c_mat, 0);
      rst = 1;
      return;
    end
    n = 0;
    while (done_cnt < target && n < 300) begin
      @(posedge clk); #1; n++;
      if (poke && out_valid && !poked) begin
        start = 1; poked = 1;
      end else begin
        start = 0;
      end
    end
    start = 0;
    if (done_cnt < target) begin
      n_cmp++; n_err++;
      $display("FAIL job_done_wait: got %0d results expected %0d", done_cnt, target);
    end
  endtask

  initial begin
    rst = 0; start = 0; a_mat = '0; b_mat = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_arr", {arr_clr, arr_load, arr_row0, arr_row1, arr_col0, arr_col1}, 0);
    chk("rst_c_mat", c_mat, 0);
    chk("rst_c_carry_tmo", {c_carry, timeout_err}, 0);
    rst = 1;
    @(posedge clk); #1;

    run_job(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 4, 3, 0, 0);
    chk("basic_r00", cur_prod[0 +: 64], 19);
    chk("basic_r11", cur_prod[192 +: 64], 50);
    run_job(pack4(32'h10, 32'h11, 32'h12, 32'h13), pack4(32'h20, 32'h21, 32'h22, 32'h23), 2, 0, 0, 0);
    run_job({4{$urandom}}, {4{$urandom}}, 1000, 1, 0, 0);
    run_job({4{$urandom}}, {4{$urandom}}, 6, 10, 1, 0);
    run_job({4{$urandom}}, {4{$urandom}}, DMAX - 1, 0, 0, 0);
    run_job({4{$urandom}}, {4{$urandom}}, 3, 0, 0, 1);
    run_job(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 0, 2, 0, 0);
    for (int j = 0; j < 20; j++)
      run_job({4{$urandom}}, {4{$urandom}}, $urandom_range(0, DMAX + 3),
              $urandom_range(0, 3), 1'($urandom), 0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/systolic_2x2_seq.md
Name: systolic_2x2_seq

Overview:
Sequencer for the 2x2 systolic multiplier array.
- Accepts one 2x2 A and one 2x2 B operand set per job through a valid/ready handshake.
- Clears the array, then streams operands in diagonal-skewed order with the array load strobe asserted.
- Waits for the array done pulse, or times out, then captures the four 65-bit results and holds them on a valid/ready output handshake.

Parameters:
DATA_W, 32, operand element width; array result width is 2*DATA_W plus 1 carry bit.
DRAIN_MAX, 16, maximum DRAIN cycles allowed before a timeout; legal range 1 to 255.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous reset, active-low.
start  in  1  job request; operands valid.
in_ready  out  1  controller can accept a job.
a_mat  in  4*DATA_W  A elements packed {a11,a10,a01,a00}; a00 in the LSBs.
b_mat  in  4*DATA_W  B elements packed {b11,b10,b01,b00}; b00 in the LSBs.
arr_clr  out  1  active-high clear to the array's rst.
arr_load  out  1  to the array's load_in.
arr_row0, arr_row1  out  DATA_W each  array row inputs.
arr_col0, arr_col1  out  DATA_W each  array column inputs.
arr_res  in  4*2*DATA_W  array results packed {r11,r10,r01,r00}.
arr_carry  in  4  array carries {c11,c10,c01,c00}.
arr_done  in  1  array done pulse.
c_mat  out  4*2*DATA_W  captured results, same packing as arr_res.
c_carry  out  4  captured carries.
timeout_err  out  1  current result was produced by a timeout.
out_valid  out  1  result available.
out_ready  in  1  consumer accepts the result.
busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE.
  - All outputs 0 except in_ready=1; c_mat, c_carry and timeout_err are also 0.
  - Reset mid-job aborts immediately; no partial result is ever presented.
- States: IDLE, CLR, FEED0, FEED1, FEED2, DRAIN, HOLD.
- IDLE:
  - in_ready=1.
  - On start&in_ready, latch a_mat and b_mat and go to CLR.
  - start while not in IDLE is ignored; no queuing.
- CLR: one cycle with arr_clr=1, arr_load=0, data buses 0. Then FEED0.
- FEED0..FEED2: arr_load=1. Buses per state (rows fed A row-major, columns fed B column-major):
  - FEED0: row0=a00, row1=0, col0=b00, col1=0.
  - FEED1: row0=a01, row1=a10, col0=b10, col1=b01.
  - FEED2: row0=0, row1=a11, col0=0, col1=b11.
- DRAIN:
  - arr_load=0, buses 0; an 8-bit drain counter starts at 0 and increments each cycle.
  - On arr_done=1: capture arr_res and arr_carry into c_mat/c_carry, set timeout_err=0, go to HOLD.
  - Else if counter==DRAIN_MAX-1: capture arr_res and arr_carry anyway, set timeout_err=1, go to HOLD.
  - arr_done and timeout in the same cycle: arr_done wins, so timeout_err=0.
- HOLD:
  - out_valid=1; c_mat, c_carry and timeout_err stay stable.
  - On out_ready=1: out_valid drops at the next edge and state returns to IDLE.
  - in_ready rises the cycle after the handshake, so back-to-back jobs are spaced at least one IDLE cycle apart.
- Output register rules:
  - c_mat, c_carry and timeout_err keep their last values until the next capture.
  - arr_done outside DRAIN is ignored.
- Latency: job accepted at edge T gives CLR in cycle T+1, FEED in T+2..T+4, DRAIN from T+5. out_valid rises at the edge after arr_done is sampled.
- Arithmetic: no arithmetic on data; the packing and bit order of arr_res/arr_carry are preserved exactly.
- Array-side outputs (arr_clr, arr_load and the four data buses) are all registered.

Test Plan:
- Basic job:
  - Stimulus: A={1,2;3,4}, B={5,6;7,8}; model array pulses arr_done 4 cycles into DRAIN with res00..11 = 19, 22, 43, 50.
  - Required: c_mat holds 19, 22, 43, 50; timeout_err=0; out_valid held until out_ready.
- Skew check:
  - Stimulus: distinct elements, e.g. a_ij=0x10+ij and b_ij=0x20+ij.
  - Required: FEED0..FEED2 bus values exactly as tabulated; arr_load high for exactly 3 cycles; arr_clr high for exactly 1 cycle before them.
- Timeout:
  - Stimulus: arr_done never asserted, DRAIN_MAX=16.
  - Required: out_valid rises after 16 DRAIN cycles; timeout_err=1.
- Back-pressure:
  - Stimulus: hold out_ready=0 for 10 cycles; pulse start during HOLD.
  - Required: result stable throughout; start ignored; in_ready=0 until after the handshake.
- Tie-break:
  - Stimulus: arr_done asserted in the final DRAIN cycle (counter=DRAIN_MAX-1).
  - Required: timeout_err=0.
- Reset mid-job:
  - Stimulus: rst=0 during FEED1.
  - Required: next cycle state=IDLE, arr_load=0, out_valid=0, in_ready=1, c_mat=0; a following job completes normally.
